bfly_net_pipe: RTL and testbench
================================

Name: bfly_net_pipe

Overview:
- Parametrised, pipelined successor of the 32-bit inverse-butterfly permutation network in the bit-manipulation unit.
- Supports XLEN 32 or 64.
- Runs in either forward (butterfly) or inverse (ibutterfly) mode per transaction.
- Has configurable pipeline register placement and valid/ready handshakes on both sides, so it sits between the bitmanip decode stage and writeback under backpressure.

Parameters:
- XLEN, 32, data width; must be a power of two, 32 or 64.
- PIPE_EVERY, 2, register after every PIPE_EVERY-th network stage; the final stage is always registered. Range 1..log2(XLEN).
- Derived, not overridable: LOG = log2(XLEN); NREG = number of register slots = ceil(LOG/PIPE_EVERY).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  input transaction valid
- ready_out  out  1  block can accept an input this cycle
- mode_in  in  1  0 = inverse (distance 1 first), 1 = forward (distance XLEN/2 first)
- cfg_in  in  LOG*XLEN/2  control bits; slice k (bits k*XLEN/2 +: XLEN/2) controls the distance-2^k stage
- data_in  in  XLEN  operand
- valid_out  out  1  result valid
- ready_in  in  1  downstream accepts result
- data_out  out  XLEN  permuted result
- busy  out  1  OR of all slot valid bits

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Stage switch:
  - A stage of distance d pairs bits j and j+d for every j with bit log2(d) of j equal to 0.
  - Pair index p = (j/(2d))*d + (j mod d).
  - ctl = cfg slice[p]. ctl=1 swaps the pair, ctl=0 passes it.
- Stage order:
  - mode 0 applies k = 0,1,...,LOG-1.
  - mode 1 applies k = LOG-1,...,0.
  - Forward and inverse with the same cfg are mutual inverses.
- Pipeline:
  - Stages are counted in processing order 1..LOG.
  - A register slot follows stage s when s mod PIPE_EVERY == 0 or s == LOG.
  - Each slot holds valid, data, mode and the full cfg. Unused cfg bits may be pruned by synthesis; behaviour is unchanged.
- Latency: exactly NREG cycles from acceptance (valid_in & ready_out) to valid_out when ready_in is held high. Throughput is 1 per cycle.
- Handshake:
  - Slot i loads when it is empty or slot i+1 (the output for the last slot) advances that cycle.
  - ready_out = slot 0 loads-capable (combinational through ready_in allowed).
  - valid_out = last slot valid. data_out = last slot data.
  - While valid_out=1 and ready_in=0, data_out is held stable.
  - Capacity is NREG transactions. Results leave in order; no drop, no duplication.
- Bubbles: empty slots collapse, so a later transaction never waits behind an empty slot.
- Reset:
  - All slot valids go to 0 and all slot data to 0.
  - After reset: valid_out=0, data_out=0, busy=0, ready_out=1.
  - Reset mid-operation discards all in-flight transactions. Inputs presented during rst are not accepted.
- Simultaneous events:
  - Acceptance and output retirement in the same cycle are both honoured.
  - Full pipeline with ready_in=1 still accepts a new input.
- Illegal parameters (XLEN not 32/64, PIPE_EVERY out of range) trip an elaboration-time $error.

Optional Feature:
- BFLY_NET_FLUSH_EN defined:
  - Adds input port flush (1 bit).
  - flush=1 clears all slot valids at the next edge; data is don't-care.
  - ready_out=0 in the flush cycle, so no input is accepted.
  - flush has lower priority than rst.
- Undefined: no flush port; the pipeline is cleared only by rst.

Decomposition:
- Package bfly_pkg:
  - bfly_mode_e enum (BFLY_INV=0, BFLY_FWD=1).
  - Function pair_idx(j, k).
  - Function clog2-based LOG helper.
  - Constants XLEN_MAX=64.
- Sub-module bfly_stage: combinational single stage, parameters XLEN and K, ports data in/out and XLEN/2 controls. Instantiated LOG times in generate, with muxed stage order per mode.

Test Plan (XLEN=32, PIPE_EVERY=2 → NREG=3):
- cfg all 0, mode 0, data 0xDEADBEEF → 0xDEADBEEF on valid_out exactly 3 cycles after acceptance.
- mode 0, slice 0 all ones, others 0, data 0xAAAAAAAA → 0x55555555; data 0x00000001 → 0x00000002.
- mode 1, slice 4 all ones, others 0, data 0x0000FFFF → 0xFFFF0000. Random cfg C, data X forward, then the result inverse with C → X (1000 random pairs).
- ready_in=0 for 6 cycles, valid_in held with 5 distinct operands → exactly 3 accepted, then ready_out=0. Release ready_in → 5 results in order, data_out stable while stalled.
- 2 transactions in flight, rst pulsed 1 cycle → next cycle valid_out=0, data_out=0, busy=0; the stale results never appear.
- With BFLY_NET_FLUSH_EN: 3 in flight, flush 1 cycle → valid_out=0 next cycle, ready_out=0 during flush. A new input after flush is output after 3 cycles.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared types and index helpers for the pipelined butterfly permutation network.
package bfly_pkg;

    typedef enum logic {
        BFLY_INV = 1'b0,
        BFLY_FWD = 1'b1
    } bfly_mode_e;

    localparam int XLEN_MAX = 64;

    function automatic int bfly_log(input int xlen);
        return $clog2(xlen);
    endfunction

    // Control bit index for the pair whose low bit is j in the distance-2^k stage.
    function automatic int pair_idx(input int j, input int k);
        return ((j >> (k + 1)) << k) | (j & ((1 << k) - 1));
    endfunction

    // Inverse of pair_idx: low bit position of pair p in the distance-2^k stage.
    function automatic int pair_lo(input int p, input int k);
        return ((p >> k) << (k + 1)) | (p & ((1 << k) - 1));
    endfunction

endpackage

// File: rtl/bfly_stage.sv
// One combinational butterfly stage of distance 2^K: each control bit swaps one bit pair.
module bfly_stage
    import bfly_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int K    = 0
) (
    input  logic [XLEN-1:0]   src,
    input  logic [XLEN/2-1:0] ctl,
    output logic [XLEN-1:0]   res
);

    localparam int D = 1 << K;

    always_comb begin
        res = src;
        for (int p = 0; p < XLEN / 2; p++) begin
            if (ctl[p]) begin
                res[pair_lo(p, K)]     = src[pair_lo(p, K) + D];
                res[pair_lo(p, K) + D] = src[pair_lo(p, K)];
            end
        end
    end

endmodule

// File: rtl/bfly_net_pipe.sv
// Pipelined forward/inverse butterfly network with valid/ready handshakes on both sides.
// Optional synchronous pipeline flush port enabled by defining BFLY_NET_FLUSH_EN.
module bfly_net_pipe
    import bfly_pkg::*;
#(
    parameter int  XLEN       = 32,
    parameter int  PIPE_EVERY = 2,
    localparam int LOG        = bfly_log(XLEN),
    localparam int HALF       = XLEN / 2,
    localparam int CFG_W      = LOG * HALF,
    localparam int PE_SAFE    = (PIPE_EVERY < 1) ? 1 : PIPE_EVERY,
    localparam int NREG       = (LOG + PE_SAFE - 1) / PE_SAFE
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BFLY_NET_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             mode_in,
    input  logic [CFG_W-1:0] cfg_in,
    input  logic [XLEN-1:0]  data_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [XLEN-1:0]  data_out,
    output logic             busy
);

    localparam int NMID = (NREG > 1) ? NREG - 1 : 1;

    if (!(XLEN == 32 || XLEN == 64) || XLEN > XLEN_MAX) begin : g_bad_xlen
        $error("bfly_net_pipe: XLEN must be 32 or 64");
    end
    if (PIPE_EVERY < 1 || PIPE_EVERY > LOG) begin : g_bad_pipe
        $error("bfly_net_pipe: PIPE_EVERY must be in 1..log2(XLEN)");
    end

    logic             vld_p  [NREG];
    logic [XLEN-1:0]  data_p [NREG];
    logic             mode_p [NMID];
    logic [CFG_W-1:0] cfg_p  [NMID];

    logic             src_vld  [NREG];
    logic             src_mode [NREG];
    logic [CFG_W-1:0] src_cfg  [NREG];
    logic [XLEN-1:0]  src_data [NREG];

    logic [NREG-1:0]  ld;
    logic             flush_c;

`ifdef BFLY_NET_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    assign src_vld[0]  = valid_in & ~flush_c;
    assign src_mode[0] = mode_in;
    assign src_cfg[0]  = cfg_in;
    assign src_data[0] = data_in;

    for (genvar i = 1; i < NREG; i++) begin : g_src
        assign src_vld[i]  = vld_p[i-1];
        assign src_mode[i] = mode_p[i-1];
        assign src_cfg[i]  = cfg_p[i-1];
        assign src_data[i] = data_p[i-1];
    end

    // A slot can load when empty or when its successor advances; empty slots collapse.
    always_comb begin
        ld = '0;
        ld[NREG-1] = ~vld_p[NREG-1] | ready_in;
        for (int i = NREG - 2; i >= 0; i--) begin
            ld[i] = ~vld_p[i] | ld[i+1];
        end
    end

    // Processing position s uses distance 2^(s-1) in inverse mode and 2^(LOG-s) in forward mode.
    for (genvar s = 1; s <= LOG; s++) begin : g_stage
        localparam int SL = (s - 1) / PE_SAFE;
        logic [XLEN-1:0] sin;
        logic [XLEN-1:0] sout;
        logic [XLEN-1:0] inv_res;
        logic [XLEN-1:0] fwd_res;

        if ((s - 1) % PE_SAFE == 0) begin : g_head
            assign sin = src_data[SL];
        end else begin : g_body
            assign sin = g_stage[s-1].sout;
        end

        bfly_stage #(.XLEN(XLEN), .K(s - 1)) u_inv (
            .src (sin),
            .ctl (src_cfg[SL][(s-1)*HALF +: HALF]),
            .res (inv_res)
        );

        bfly_stage #(.XLEN(XLEN), .K(LOG - s)) u_fwd (
            .src (sin),
            .ctl (src_cfg[SL][(LOG-s)*HALF +: HALF]),
            .res (fwd_res)
        );

        assign sout = (bfly_mode_e'(src_mode[SL]) == BFLY_FWD) ? fwd_res : inv_res;
    end

    for (genvar i = 0; i < NREG; i++) begin : g_slot
        localparam int LAST = ((i + 1) * PE_SAFE < LOG) ? (i + 1) * PE_SAFE : LOG;

        // ---- slot i register boundary ----
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end else if (flush_c) begin
                vld_p[i] <= 1'b0;
            end else if (ld[i]) begin
                vld_p[i] <= src_vld[i];
                if (src_vld[i]) begin
                    data_p[i] <= g_stage[LAST].sout;
                end
            end
        end

        // The last slot only feeds data_out, so mode/cfg travel only through earlier slots.
        if (i < NREG - 1) begin : g_ctl
            always_ff @(posedge clk) begin
                if (ld[i] && src_vld[i]) begin
                    mode_p[i] <= src_mode[i];
                    cfg_p[i]  <= src_cfg[i];
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            busy = busy | vld_p[i];
        end
    end

    assign ready_out = ld[0] & ~flush_c;
    assign valid_out = vld_p[NREG-1];
    assign data_out  = data_p[NREG-1];

endmodule

// File: tb/tb_bfly_net_pipe.sv
// Directed bench for bfly_net_pipe at XLEN=32, PIPE_EVERY=2 (three register slots).
module tb_bfly_net_pipe;

    localparam int XLEN = 32;
    localparam int CFGW = 80;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic            ready_out;
    logic            mode_in;
    logic [CFGW-1:0] cfg_in;
    logic [XLEN-1:0] data_in;
    logic            valid_out;
    logic            ready_in;
    logic [XLEN-1:0] data_out;
    logic            busy;
`ifdef BFLY_NET_FLUSH_EN
    logic            flush;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bfly_net_pipe #(.XLEN(XLEN), .PIPE_EVERY(2)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BFLY_NET_FLUSH_EN
        .flush     (flush),
`endif
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .mode_in   (mode_in),
        .cfg_in    (cfg_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CFGW-1:0] slice_cfg(input int k, input logic [15:0] v);
        logic [CFGW-1:0] c;
        c = '0;
        c[k*16 +: 16] = v;
        return c;
    endfunction

    // One transaction into an idle pipe; returns the result and cycles until valid_out.
    task automatic xact(input logic m, input logic [CFGW-1:0] c, input logic [31:0] d,
                        output logic [31:0] r, output int lat);
        mode_in  = m;
        cfg_in   = c;
        data_in  = d;
        valid_in = 1'b1;
        ready_in = 1'b1;
        tick();
        valid_in = 1'b0;
        lat = 1;
        while (valid_out !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        r = data_out;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]     r;
        logic [31:0]     y;
        logic [31:0]     z;
        logic [31:0]     x;
        logic [CFGW-1:0] c;
        int              lat;
        int              lat2;
        int              idx;
        int              got;
        logic [31:0]     ops [5];

        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        mode_in  = 1'b0;
        cfg_in   = '0;
        data_in  = '0;
`ifdef BFLY_NET_FLUSH_EN
        flush    = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_data_out", data_out, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready_out", 32'(ready_out), 32'd1);

        xact(1'b0, '0, 32'hDEADBEEF, r, lat);
        chk("identity_latency", 32'(lat), 32'd3);
        chk("identity_data", r, 32'hDEADBEEF);

        xact(1'b0, slice_cfg(0, 16'hFFFF), 32'hAAAAAAAA, r, lat);
        chk("swap_adjacent_aa", r, 32'h55555555);
        xact(1'b0, slice_cfg(0, 16'hFFFF), 32'h00000001, r, lat);
        chk("swap_adjacent_one", r, 32'h00000002);

        xact(1'b1, slice_cfg(4, 16'hFFFF), 32'h0000FFFF, r, lat);
        chk("swap_halves_fwd", r, 32'hFFFF0000);
        chk("swap_halves_latency", 32'(lat), 32'd3);

        xact(1'b0, slice_cfg(2, 16'h0020), 32'h00000200, r, lat);
        chk("pair_index_d4_p5", r, 32'h00002000);

        c = slice_cfg(0, 16'h0001) | slice_cfg(1, 16'h0001);
        xact(1'b0, c, 32'h00000001, r, lat);
        chk("order_inverse", r, 32'h00000002);
        xact(1'b1, c, 32'h00000001, r, lat);
        chk("order_forward", r, 32'h00000004);

        for (int n = 0; n < 1000; n++) begin
            c = {$urandom(), $urandom(), 16'($urandom())};
            x = $urandom();
            xact(1'b1, c, x, y, lat);
            xact(1'b0, c, y, z, lat2);
            chk("roundtrip", z, x);
        end

        // Backpressure: downstream stalled while five operands are offered.
        tick();
        mode_in  = 1'b0;
        cfg_in   = '0;
        ready_in = 1'b0;
        ops[0] = 32'h11111111;
        ops[1] = 32'h22222222;
        ops[2] = 32'h33333333;
        ops[3] = 32'h44444444;
        ops[4] = 32'h55555555;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            data_in  = ops[(idx < 5) ? idx : 4];
            valid_in = 1'b1;
            #1;
            if (cyc >= 3) chk("stall_ready_out", 32'(ready_out), 32'd0);
            if (ready_out) idx++;
            tick();
        end
        chk("stall_accepted", 32'(idx), 32'd3);
        chk("stall_valid_out", 32'(valid_out), 32'd1);
        chk("stall_data_a", data_out, ops[0]);
        tick();
        chk("stall_data_b", data_out, ops[0]);
        chk("stall_busy", 32'(busy), 32'd1);

        ready_in = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            data_in  = ops[(idx < 5) ? idx : 4];
            valid_in = (idx < 5);
            #1;
            if (valid_out) begin
                chk("drain_order", data_out, ops[got]);
                got++;
            end
            if (ready_out && valid_in) idx++;
            tick();
        end
        valid_in = 1'b0;
        chk("drain_count", 32'(got), 32'd5);
        tick();
        chk("drain_idle_valid", 32'(valid_out), 32'd0);

        // Reset with two transactions in flight.
        data_in  = 32'hA5A5A5A5;
        valid_in = 1'b1;
        tick();
        data_in = 32'h5A5A5A5A;
        tick();
        chk("inflight_busy", 32'(busy), 32'd1);
        rst     = 1'b1;
        data_in = 32'h0F0F0F0F;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("midreset_valid_out", 32'(valid_out), 32'd0);
        chk("midreset_data_out", data_out, 32'h0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_ready_out", 32'(ready_out), 32'd1);
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            chk("midreset_no_stale", 32'(valid_out), 32'd0);
        end

`ifdef BFLY_NET_FLUSH_EN
        // Flush with the pipe full.
        ready_in = 1'b1;
        valid_in = 1'b1;
        data_in  = 32'h01010101;
        tick();
        data_in = 32'h02020202;
        tick();
        data_in = 32'h03030303;
        tick();
        chk("preflush_valid_out", 32'(valid_out), 32'd1);
        flush   = 1'b1;
        data_in = 32'h04040404;
        #1;
        chk("flush_ready_out", 32'(ready_out), 32'd0);
        tick();
        flush    = 1'b0;
        valid_in = 1'b0;
        chk("postflush_valid_out", 32'(valid_out), 32'd0);
        chk("postflush_busy", 32'(busy), 32'd0);
        xact(1'b0, '0, 32'hCAFEF00D, r, lat);
        chk("postflush_latency", 32'(lat), 32'd3);
        chk("postflush_data", r, 32'hCAFEF00D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
